// File: rtl/core_mem_arbiter_pkg.sv
// Shared types for the single-port core/memory arbiter.
// State encoding and access-direction constants.
package core_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    INST,
    STEP
  } arb_state_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

endpackage

// File: rtl/core_mem_arbiter.sv
// Serialises the core's data access and instruction fetch onto one
// memory port, then advances the core by one enabled cycle.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        sync_rst,
  input  logic        run,
  output logic        core_clk_en,
  input  logic [29:0] inst_address,
  input  logic        bus_lock,
  input  logic        memory_mode,
  input  logic [29:0] data_address,
  input  logic [3:0]  data_mask,
  input  logic [31:0] data_out,
  output logic [31:0] inst_in,
  output logic [31:0] data_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        bus_error
);

  arb_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_inst;
  logic [31:0]      pend_data;
  logic             step_read;
  logic             launch;
  logic             timeout;
  logic             done;

  assign launch  = run && (state == IDLE || state == STEP);
  assign timeout = (TIMEOUT_CYCLES != 0) && mem_req && !mem_ready
                && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign done    = mem_req && (mem_ready || timeout);

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state       <= IDLE;
      core_clk_en <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wmask   <= '0;
      mem_wdata   <= '0;
      inst_in     <= '0;
      data_in     <= '0;
      pend_inst   <= '0;
      pend_data   <= '0;
      step_read   <= 1'b0;
      bus_error   <= 1'b0;
      cnt         <= '0;
    end else begin
      core_clk_en <= 1'b0;
      unique case (state)
        IDLE: begin
          state <= IDLE;
        end
        DATA: begin
          if (done) begin
            if (mem_we == MEM_READ)
              pend_data <= mem_ready ? mem_rdata : '0;
            if (!mem_ready)
              bus_error <= 1'b1;
            state    <= INST;
            mem_we   <= 1'b0;
            mem_addr <= inst_address;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INST: begin
          if (done) begin
            pend_inst <= mem_ready ? mem_rdata : '0;
            if (!mem_ready)
              bus_error <= 1'b1;
            state       <= STEP;
            mem_req     <= 1'b0;
            core_clk_en <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STEP: begin
          inst_in <= pend_inst;
          if (step_read)
            data_in <= pend_data;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A new step overrides the IDLE/STEP defaults above.
      if (launch) begin
        mem_req <= 1'b1;
        cnt     <= '0;
        if (bus_lock) begin
          state     <= DATA;
          mem_we    <= memory_mode;
          mem_addr  <= data_address;
          mem_wmask <= data_mask;
          mem_wdata <= data_out;
          step_read <= (memory_mode != MEM_WRITE);
        end else begin
          state     <= INST;
          mem_we    <= 1'b0;
          mem_addr  <= inst_address;
          step_read <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed plus randomized checks of the arbiter against a
// transaction-level model with a behavioural memory.
module tb_core_mem_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        sync_rst;
  logic        run;
  logic        core_clk_en;
  logic [29:0] inst_address;
  logic        bus_lock;
  logic        memory_mode;
  logic [29:0] data_address;
  logic [3:0]  data_mask;
  logic [31:0] data_out;
  logic [31:0] inst_in;
  logic [31:0] data_in;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_error;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [logic [29:0]];
  logic [31:0] exp_inst = '0;
  logic [31:0] exp_data = '0;
  logic        exp_err  = 1'b0;

  core_mem_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .sync_rst(sync_rst),
    .run(run),
    .core_clk_en(core_clk_en),
    .inst_address(inst_address),
    .bus_lock(bus_lock),
    .memory_mode(memory_mode),
    .data_address(data_address),
    .data_mask(data_mask),
    .data_out(data_out),
    .inst_in(inst_in),
    .data_in(data_in),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] rd(input logic [29:0] a);
    if (mem.exists(a))
      return mem[a];
    return 32'h9e3779b9 ^ {a, 2'b01};
  endfunction

  task automatic wr(input logic [29:0] a, input logic [3:0] mk,
                    input logic [31:0] wd);
    logic [31:0] v;
    v = rd(a);
    for (int i = 0; i < 4; i++)
      if (mk[i]) v[8*i +: 8] = wd[8*i +: 8];
    mem[a] = v;
  endtask

  task automatic set_in(input bit bl, input bit md,
                        input logic [29:0] da, input logic [3:0] mk,
                        input logic [31:0] wd, input logic [29:0] ia);
    bus_lock     = bl;
    memory_mode  = md;
    data_address = da;
    data_mask    = mk;
    data_out     = wd;
    inst_address = ia;
  endtask

  // Plays the memory for one step; wait < 0 means never ready.
  // Returns at the falling edge inside the core_clk_en pulse.
  task automatic step(input int wdw, input int wiw, input bit drop);
    int          phase;
    int          k;
    int          ncyc;
    int          exp_cyc;
    int          w;
    bit          fin;
    logic [31:0] v;
    phase   = bus_lock ? 0 : 1;
    k       = 0;
    ncyc    = 0;
    fin     = 1'b0;
    exp_cyc = (wiw < 0) ? TO : wiw + 1;
    if (bus_lock)
      exp_cyc += (wdw < 0) ? TO : wdw + 1;
    for (int c = 0; c < 64 && !fin; c++) begin
      @(negedge clk);
      if (core_clk_en) begin
        chk("pulse_phase", 32'(phase), 32'd2);
        chk("step_cycles", 32'(ncyc), 32'(exp_cyc));
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
        fin = 1'b1;
      end else begin
        ncyc++;
        chk("mem_req", 32'(mem_req), 32'd1);
        if (phase == 0) begin
          chk("d_addr", 32'(mem_addr), 32'(data_address));
          chk("d_we", 32'(mem_we), 32'(memory_mode));
          if (memory_mode) begin
            chk("d_mask", 32'(mem_wmask), 32'(data_mask));
            chk("d_wdata", mem_wdata, data_out);
          end
          w = wdw;
        end else begin
          chk("i_addr", 32'(mem_addr), 32'(inst_address));
          chk("i_we", 32'(mem_we), 32'd0);
          w = wiw;
        end
        mem_rdata = $urandom;
        mem_ready = 1'b0;
        if (w >= 0 && k == w) begin
          mem_ready = 1'b1;
          if (phase == 0) begin
            if (memory_mode) begin
              wr(data_address, data_mask, data_out);
            end else begin
              v = rd(data_address);
              mem_rdata = v;
              exp_data = v;
            end
          end else begin
            v = rd(inst_address);
            mem_rdata = v;
            exp_inst = v;
          end
          phase++;
          k = 0;
        end else if (w < 0 && k == TO - 1) begin
          exp_err = 1'b1;
          if (phase == 0 && !memory_mode) exp_data = '0;
          if (phase == 1) exp_inst = '0;
          phase++;
          k = 0;
        end else begin
          k++;
        end
        if (drop && c == 0) run = 1'b0;
      end
    end
    if (!fin) begin
      total++;
      bad++;
      $error("FAIL step_bound observed=no_pulse expected=pulse");
    end
  endtask

  task automatic finish_step();
    @(posedge clk);
    #1;
    chk("inst_in", inst_in, exp_inst);
    chk("data_in", data_in, exp_data);
    chk("bus_error", 32'(bus_error), 32'(exp_err));
    chk("no_double_pulse", 32'(core_clk_en), 32'd0);
  endtask

  initial begin
    sync_rst  = 1'b1;
    run       = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    set_in(0, 0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_clk_en", 32'(core_clk_en), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_mask", 32'(mem_wmask), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_inst", inst_in, 32'd0);
    chk("rst_data", data_in, 32'd0);
    chk("rst_err", 32'(bus_error), 32'd0);
    sync_rst = 1'b0;

    // Zero-wait fetch-only steps.
    mem[30'h10] = 32'h0000_0013;
    set_in(0, 0, '0, '0, '0, 30'h10);
    run = 1'b1;
    step(0, 0, 0);
    finish_step();
    chk("nop_fetch", inst_in, 32'h0000_0013);
    step(0, 0, 0);
    finish_step();
    step(0, 0, 0);
    mem[30'h40] = 32'hdead_beef;
    mem[30'h11] = 32'h00a0_0093;
    set_in(1, 0, 30'h40, '0, '0, 30'h11);
    finish_step();

    // Load, then a store with wait states, then read back.
    step(0, 0, 0);
    set_in(1, 1, 30'h40, 4'b0011, 32'h1234_abcd, 30'h12);
    finish_step();
    chk("load_val", data_in, 32'hdead_beef);
    chk("load_inst", inst_in, 32'h00a0_0093);
    step(2, 0, 0);
    set_in(1, 0, 30'h40, '0, '0, 30'h13);
    finish_step();
    chk("store_hold", data_in, 32'hdead_beef);
    step(0, 1, 0);
    set_in(1'($urandom), 1'($urandom), 30'($urandom_range(15)),
           4'($urandom), $urandom, 30'($urandom_range(15)));
    finish_step();
    chk("merged", data_in, 32'hdead_abcd);

    // Random steps with legal wait states.
    for (int i = 0; i < 40; i++) begin
      step(int'($urandom_range(3)), int'($urandom_range(3)), 0);
      set_in(1'($urandom), 1'($urandom), 30'($urandom_range(15)),
             4'($urandom), $urandom, 30'($urandom_range(15)));
      finish_step();
    end

    // run drops during the data access.
    step(int'($urandom_range(3)), int'($urandom_range(3)), 0);
    set_in(1, 0, 30'h5, '0, '0, 30'h6);
    finish_step();
    step(2, 0, 1);
    finish_step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("park_req", 32'(mem_req), 32'd0);
      chk("park_en", 32'(core_clk_en), 32'd0);
    end

    // Fetch timeout, then a normal step keeps the error.
    set_in(0, 0, '0, '0, '0, 30'h20);
    run = 1'b1;
    step(0, -1, 0);
    set_in(0, 0, '0, '0, '0, 30'h10);
    finish_step();
    chk("to_inst", inst_in, 32'd0);
    chk("to_err", 32'(bus_error), 32'd1);
    step(0, 0, 0);
    run = 1'b0;
    finish_step();
    chk("err_sticky", 32'(bus_error), 32'd1);

    // Reset during a waiting fetch.
    @(negedge clk);
    set_in(0, 0, '0, '0, '0, 30'h22);
    run = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("mid_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    mem_ready = 1'b0;
    sync_rst = 1'b1;
    run = 1'b0;
    @(posedge clk);
    #1;
    chk("mr_req", 32'(mem_req), 32'd0);
    chk("mr_inst", inst_in, 32'd0);
    chk("mr_err", 32'(bus_error), 32'd0);
    chk("mr_en", 32'(core_clk_en), 32'd0);
    chk("mr_addr", 32'(mem_addr), 32'd0);
    sync_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mr_no_pulse", 32'(core_clk_en), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
Name: core_mem_arbiter

Overview:
Single-port memory controller that sits between `core` and one unified instruction/data memory, so the core can run on a von Neumann memory.
- Gates the core's `clk_en`. For each enabled core cycle (a "step"), it first runs the data access, if any, then the instruction fetch, on the shared port.
- It then advances the core by exactly one enabled cycle.
- From the core's point of view, read results arrive one enabled cycle later, like a synchronous 1-cycle memory.

Parameters:
TIMEOUT_CYCLES, 255, maximum mem_ready wait per access before abort; 0 disables the timeout.
CNT_W, 8, width of the wait counter; must hold TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock
sync_rst  input  1  synchronous active-high reset
run  input  1  global enable; when low, no new step sequence starts
core_clk_en  output  1  drives core.clk_en; high for exactly one cycle per step
inst_address  input  30  core fetch word address
bus_lock  input  1  core data access requested this step
memory_mode  input  1  0 = read, 1 = write
data_address  input  30  core data word address
data_mask  input  4  byte enables for writes
data_out  input  32  core write data
inst_in  output  32  fetched instruction word to core
data_in  output  32  load data to core
mem_req  output  1  memory access request
mem_we  output  1  write strobe, valid with mem_req
mem_addr  output  30  word address
mem_wmask  output  4  byte mask, valid with mem_we
mem_wdata  output  32  write data
mem_ready  input  1  access complete; mem_rdata valid in the same cycle
mem_rdata  input  32  read data
bus_error  output  1  sticky flag: an access timed out

Behaviour:
Reset values:
- State is IDLE.
- core_clk_en, mem_req and mem_we are 0.
- mem_addr, mem_wmask, mem_wdata, inst_in, data_in and the pending registers are 0.
- bus_error is 0; the wait counter is 0.
- Reset asserted in any state, including mid-access, returns to IDLE on the next edge. The in-flight access is dropped without completion.

Core inputs:
- All core inputs are sampled only while core_clk_en = 0. They are stable then because the core is frozen.
- inst_req is not used: the fetch is issued every step, since re-fetching a stalled PC is harmless.

FSM states: IDLE, DATA, INST, STEP.
- IDLE: if run, go to DATA when bus_lock = 1, else go to INST.
- DATA: mem_req = 1, mem_addr = data_address, mem_we = memory_mode, mem_wmask = data_mask, mem_wdata = data_out.
  - On mem_ready: for a read, pend_data <= mem_rdata; go to INST.
- INST: mem_req = 1, mem_we = 0, mem_addr = inst_address.
  - On mem_ready: pend_inst <= mem_rdata; go to STEP.
- STEP: core_clk_en = 1 for one cycle; mem_req = 0.
  - At this edge: inst_in <= pend_inst; data_in <= pend_data, but only if the step had a read, otherwise data_in holds.
  - Next state: DATA/INST if run (same decision as IDLE), else IDLE.
- mem_ready is ignored when mem_req = 0.

Handshake:
- mem_req and all address/data/mask fields stay constant until the cycle mem_ready = 1.
- Zero-wait memory is legal: mem_ready is allowed in the first request cycle.
- Back-to-back DATA then INST deasserts nothing between them; mem_req stays high with new fields.

Timeout:
- The wait counter clears on entering DATA/INST and increments each cycle mem_req is high without mem_ready.
- When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), the access is aborted: the pending register gets 0, bus_error <= 1, and the FSM advances as if ready.
- bus_error clears only on reset.

Timing:
- Minimum step period: 2 cycles without a data access, 3 cycles with one (zero-wait memory).
- core_clk_en is never high on two consecutive cycles.

Run deasserted mid-sequence: the current step completes through STEP, then the FSM parks in IDLE.

Decomposition:
- Package core_mem_arbiter_pkg: state enum arb_state_t {IDLE, DATA, INST, STEP}, localparams MEM_READ = 0, MEM_WRITE = 1.
- No sub-module: single FSM plus counter and holding registers.

Test Plan:
- Zero-wait, no data access, inst_address = 0x10, mem_rdata = 0x00000013: core_clk_en pulses every 2nd cycle; inst_in = 0x00000013 the cycle after the pulse; mem_we is never high.
- Load: bus_lock = 1, memory_mode = 0, data_address = 0x40, memory returns 0xDEADBEEF then instruction 0x00A00093. Required: DATA then INST order; data_in = 0xDEADBEEF after STEP; 3-cycle step.
- Store: memory_mode = 1, mask = 4'b0011, data = 0x1234ABCD, 2 wait states. Required: mem_we = 1 and fields stable for 3 cycles; data_in unchanged after STEP.
- Timeout: TIMEOUT_CYCLES = 4, mem_ready stuck low. Required: abort after 4 wait cycles; bus_error = 1 and stays set; inst_in = 0; core_clk_en still pulses.
- Reset mid-INST with wait states: next cycle state = IDLE, mem_req = 0, inst_in = 0, bus_error = 0; no core_clk_en pulse.
- run dropped during DATA: the step completes (one core_clk_en pulse); afterwards there is no mem_req until run returns.
